// File: rtl/seg14_pkg.sv
// seg14_pkg: shared constants for the 14-segment scroll multiplexer.
//  - SEG_W / GLYPH_W : segment pattern and glyph code widths.
//  - G_* localparams : glyph codes (0 = space, 1..26 = A..Z, 27..36 = '0'..'9').
//  - FONT_TABLE      : 64-entry constant font, pattern order {a,b,c,d,e,f,g1,g2,h,i,j,k,l,m}.
//                      Codes 37..63 map to an all-off pattern.
package seg14_pkg;

  localparam int SEG_W   = 14;
  localparam int GLYPH_W = 6;

  localparam logic [GLYPH_W-1:0] G_SPACE = 6'd0;
  localparam logic [GLYPH_W-1:0] G_A = 6'd1,  G_B = 6'd2,  G_C = 6'd3,  G_D = 6'd4;
  localparam logic [GLYPH_W-1:0] G_E = 6'd5,  G_F = 6'd6,  G_G = 6'd7,  G_H = 6'd8;
  localparam logic [GLYPH_W-1:0] G_I = 6'd9,  G_J = 6'd10, G_K = 6'd11, G_L = 6'd12;
  localparam logic [GLYPH_W-1:0] G_M = 6'd13, G_N = 6'd14, G_O = 6'd15, G_P = 6'd16;
  localparam logic [GLYPH_W-1:0] G_Q = 6'd17, G_R = 6'd18, G_S = 6'd19, G_T = 6'd20;
  localparam logic [GLYPH_W-1:0] G_U = 6'd21, G_V = 6'd22, G_W = 6'd23, G_X = 6'd24;
  localparam logic [GLYPH_W-1:0] G_Y = 6'd25, G_Z = 6'd26;
  localparam logic [GLYPH_W-1:0] G_D0 = 6'd27, G_D1 = 6'd28, G_D2 = 6'd29, G_D3 = 6'd30;
  localparam logic [GLYPH_W-1:0] G_D4 = 6'd31, G_D5 = 6'd32, G_D6 = 6'd33, G_D7 = 6'd34;
  localparam logic [GLYPH_W-1:0] G_D8 = 6'd35, G_D9 = 6'd36;
  localparam logic [GLYPH_W-1:0] G_FIRST_BLANK = 6'd37;

  // Bit 13 = a ... bit 6 = g2, bit 5 = h (upper-left diagonal), bit 4 = i (upper vertical),
  // bit 3 = j (upper-right diagonal), bit 2 = k (lower-left diagonal), bit 1 = l (lower
  // vertical), bit 0 = m (lower-right diagonal).
  localparam logic [SEG_W-1:0] FONT_TABLE [64] = '{
    14'b00000000000000, // space
    14'b11101111000000, // A
    14'b11110001010010, // B
    14'b10011100000000, // C
    14'b11110000010010, // D
    14'b10011110000000, // E
    14'b10001110000000, // F
    14'b10111101000000, // G
    14'b01101111000000, // H
    14'b10010000010010, // I
    14'b01111000000000, // J
    14'b00001110001001, // K
    14'b00011100000000, // L
    14'b01101100101000, // M
    14'b01101100100001, // N
    14'b11111100000000, // O
    14'b11001111000000, // P
    14'b11111100000001, // Q
    14'b11001111000001, // R
    14'b10110111000000, // S
    14'b10000000010010, // T
    14'b01111100000000, // U
    14'b00001100001100, // V
    14'b01101100000101, // W
    14'b00000000101101, // X
    14'b00000000101010, // Y
    14'b10010000001100, // Z
    14'b11111100001100, // 0
    14'b01100000001000, // 1
    14'b11011011000000, // 2
    14'b11110001000000, // 3
    14'b01100111000000, // 4
    14'b10010110000001, // 5
    14'b10111111000000, // 6
    14'b11100000000000, // 7
    14'b11111111000000, // 8
    14'b11110111000000, // 9
    // 37..63: blank codes
    14'b0, 14'b0, 14'b0, 14'b0, 14'b0, 14'b0, 14'b0, 14'b0, 14'b0,
    14'b0, 14'b0, 14'b0, 14'b0, 14'b0, 14'b0, 14'b0, 14'b0, 14'b0,
    14'b0, 14'b0, 14'b0, 14'b0, 14'b0, 14'b0, 14'b0, 14'b0, 14'b0
  };

endpackage

// File: rtl/seg14_font.sv
// seg14_font: combinational glyph-code to 14-segment pattern ROM.
//  code_i  in  6   glyph code
//  seg_o   out 14  segment pattern {a..g2,h..m}, active-high; codes 37..63 give 0
module seg14_font
  import seg14_pkg::*;
(
  input  logic [GLYPH_W-1:0] code_i,
  output logic [SEG_W-1:0]   seg_o
);

  // The table is fully populated for all 64 codes, so no range guard is needed.
  assign seg_o = FONT_TABLE[code_i];

endmodule

// File: rtl/seg14_scroll_mux.sv
// seg14_scroll_mux: time-multiplexed 14-segment display driver with a writable,
// scrollable message buffer.
//  clk_i         in   1                  core clock, all logic on posedge
//  rst_i         in   1                  synchronous active-high reset
//  div_i         in   DIV_W              refresh prescaler reload (digit step every div+1 clks)
//  wr_en_i       in   1                  glyph RAM write strobe
//  wr_addr_i     in   $clog2(MSG_LEN)    glyph RAM write address
//  wr_glyph_i    in   6                  glyph code to write
//  msg_len_i     in   $clog2(MSG_LEN)+1  active message length, clamped to MSG_LEN
//  scroll_en_i   in   1                  1 = advance offset, 0 = hold
//  scroll_div_i  in   SCR_W              offset advances every scroll_div+1 frames
//  blink_i       in   1                  blink request (used only with SEG14_BLINK_EN)
//  sel_o         out  DIGITS             one-hot digit select
//  segm_o        out  14                 segment pattern
//  frame_tick_o  out  1                  1-clk pulse while the last digit is freshly driven
// Build option: define SEG14_BLINK_EN to build the blink-phase logic; otherwise blink_i
// is accepted and ignored.
// MSG_LEN must be a power of two >= 2 and >= DIGITS.
module seg14_scroll_mux
  import seg14_pkg::*;
#(
  parameter int DIGITS  = 12,
  parameter int MSG_LEN = 32,
  parameter int DIV_W   = 16,
  parameter int SCR_W   = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [DIV_W-1:0]             div_i,
  input  logic                         wr_en_i,
  input  logic [$clog2(MSG_LEN)-1:0]   wr_addr_i,
  input  logic [GLYPH_W-1:0]           wr_glyph_i,
  input  logic [$clog2(MSG_LEN):0]     msg_len_i,
  input  logic                         scroll_en_i,
  input  logic [SCR_W-1:0]             scroll_div_i,
  input  logic                         blink_i,
  output logic [DIGITS-1:0]            sel_o,
  output logic [SEG_W-1:0]             segm_o,
  output logic                         frame_tick_o
);

  localparam int AW = $clog2(MSG_LEN);
  localparam int LW = AW + 1;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // ---------------------------------------------------------------- prescaler
  logic [DIV_W-1:0] presc_q;
  logic             tick;

  assign tick = (presc_q == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_q <= '0;
    end else begin
      // div_i is only sampled on reload, so a change waits for the current count.
      presc_q <= tick ? div_i : presc_q - DIV_W'(1);
    end
  end

  // ---------------------------------------------------------------- glyph RAM
  logic [GLYPH_W-1:0] ram_q [MSG_LEN];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        ram_q[i] <= G_SPACE;
      end
    end else if (wr_en_i) begin
      ram_q[wr_addr_i] <= wr_glyph_i;
    end
  end

  // ---------------------------------------------------------------- read path
  logic [LW-1:0]      len_eff;
  logic               len_empty;
  logic [DW-1:0]      digit_q;
  logic               last_digit;
  logic [AW-1:0]      offset_q;
  logic [AW-1:0]      ptr_q;
  logic [AW-1:0]      base_addr;
  logic [AW-1:0]      rd_addr;
  logic [LW-1:0]      rd_plus1;
  logic [AW-1:0]      rd_addr_inc;
  logic [GLYPH_W-1:0] rd_glyph;
  logic [SEG_W-1:0]   font_seg;
  logic               blank;

  assign len_eff    = (msg_len_i > LW'(MSG_LEN)) ? LW'(MSG_LEN) : msg_len_i;
  assign len_empty  = (len_eff == '0);
  assign last_digit = (digit_q == DW'(DIGITS - 1));

  // ptr_q walks (offset + d) mod L one digit at a time, avoiding a true modulo.
  // Digit 0 restarts from the offset; any index at or beyond L (message just
  // shrank) is folded back to 0.
  assign base_addr   = (digit_q == '0) ? offset_q : ptr_q;
  assign rd_addr     = ({1'b0, base_addr} >= len_eff) ? '0 : base_addr;
  assign rd_plus1    = {1'b0, rd_addr} + LW'(1);
  assign rd_addr_inc = (rd_plus1 >= len_eff) ? '0 : rd_plus1[AW-1:0];

  // Asynchronous array read: a write landing on the same edge is seen on the next read.
  assign rd_glyph = ram_q[rd_addr];

  seg14_font u_font (
    .code_i (rd_glyph),
    .seg_o  (font_seg)
  );

  // ---------------------------------------------------------------- scan and outputs
  logic [DIGITS-1:0] sel_q, sel_d;
  logic [SEG_W-1:0]  segm_q, segm_d;
  logic              frame_tick_q;
  logic              frame_evt;

  assign frame_evt = tick && last_digit;
  assign sel_d     = DIGITS'(1) << digit_q;
  assign segm_d    = (len_empty || blank) ? '0 : font_seg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      digit_q      <= '0;
      ptr_q        <= '0;
      sel_q        <= '0;
      segm_q       <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      frame_tick_q <= frame_evt;
      if (tick) begin
        sel_q   <= sel_d;
        segm_q  <= segm_d;
        ptr_q   <= rd_addr_inc;
        digit_q <= last_digit ? '0 : digit_q + DW'(1);
      end
    end
  end

  assign sel_o        = sel_q;
  assign segm_o       = segm_q;
  assign frame_tick_o = frame_tick_q;

  // ---------------------------------------------------------------- scroll
  // The frame event is taken on the edge that drives the last digit (the edge that
  // raises frame_tick), so the new offset is already in place for the next digit 0
  // even when div=0 and the following tick is back-to-back.
  logic [SCR_W-1:0] fdiv_q;
  logic             scroll_step;
  logic [LW-1:0]    offset_plus1;

  assign scroll_step  = frame_evt && scroll_en_i && (fdiv_q == '0);
  assign offset_plus1 = {1'b0, offset_q} + LW'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fdiv_q   <= '0;
      offset_q <= '0;
    end else begin
      if (frame_evt && scroll_en_i) begin
        fdiv_q <= (fdiv_q == '0) ? scroll_div_i : fdiv_q - SCR_W'(1);
      end
      if (scroll_step) begin
        offset_q <= (offset_plus1 >= len_eff) ? '0 : offset_plus1[AW-1:0];
      end else if (tick && ({1'b0, offset_q} >= len_eff)) begin
        // Covers both an empty message and a message that shrank below the offset.
        offset_q <= '0;
      end
    end
  end

  // ---------------------------------------------------------------- blink
`ifdef SEG14_BLINK_EN
  logic [4:0] blink_cnt_q;
  logic       blink_phase_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (!blink_i) begin
      if (tick) begin
        blink_cnt_q   <= '0;
        blink_phase_q <= 1'b0;
      end
    end else if (frame_evt) begin
      // Phase flips on every 32nd frame while blinking.
      blink_cnt_q <= blink_cnt_q + 5'd1;
      if (blink_cnt_q == 5'd31) begin
        blink_phase_q <= ~blink_phase_q;
      end
    end
  end

  assign blank = blink_i && blink_phase_q;
`else
  logic unused_blink;
  assign unused_blink = blink_i;
  assign blank        = 1'b0;
`endif

endmodule

// File: tb/tb_seg14_scroll_mux.sv
// tb_seg14_scroll_mux: directed self-checking bench for seg14_scroll_mux
// (DIGITS=12, MSG_LEN=32). Inputs change 1 time unit after posedge and outputs
// are sampled there too.
module tb_seg14_scroll_mux;

  localparam logic [13:0] F_A = 14'b11101111000000;
  localparam logic [13:0] F_E = 14'b10011110000000;
  localparam logic [13:0] F_M = 14'b01101100101000;
  localparam logic [13:0] F_T = 14'b10000000010010;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] div;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [5:0]  wr_glyph;
  logic [5:0]  msg_len;
  logic        scroll_en;
  logic [7:0]  scroll_div;
  logic        blink;
  logic [11:0] sel;
  logic [13:0] segm;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg14_scroll_mux #(
    .DIGITS(12), .MSG_LEN(32), .DIV_W(16), .SCR_W(8)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .div_i        (div),
    .wr_en_i      (wr_en),
    .wr_addr_i    (wr_addr),
    .wr_glyph_i   (wr_glyph),
    .msg_len_i    (msg_len),
    .scroll_en_i  (scroll_en),
    .scroll_div_i (scroll_div),
    .blink_i      (blink),
    .sel_o        (sel),
    .segm_o       (segm),
    .frame_tick_o (frame_tick)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    wr_en = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic write_glyph(input logic [4:0] addr, input logic [5:0] g);
    wr_addr  = addr;
    wr_glyph = g;
    wr_en    = 1'b1;
    step();
    wr_en = 1'b0;
  endtask

  // Advance until frame_tick is seen (sel=0x800 just driven); bounded.
  task automatic sync_frame();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!frame_tick && n < 300);
    checks++;
    if (frame_tick !== 1'b1) begin
      errors++;
      $display("FAIL sync_frame: frame_tick=%b after %0d clks, required 1", frame_tick, n);
    end
  endtask

  task automatic test_reset();
    msg_len = 6'd32; div = 16'd0; scroll_en = 1'b0;
    rst = 1'b1;
    step();
    step();
    checks++;
    if (sel !== 12'h000) begin errors++; $display("FAIL reset_sel: got %h required 000", sel); end
    checks++;
    if (segm !== 14'h0) begin errors++; $display("FAIL reset_segm: got %b required 0", segm); end
    checks++;
    if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_frame_tick: got %b required 0", frame_tick); end
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      checks++;
      if (sel !== 12'(1 << k) || segm !== 14'h0) begin
        errors++;
        $display("FAIL reset_ram_space d=%0d: sel=%h segm=%b required sel=%h segm=0", k, sel, segm, 12'(1 << k));
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_static();
    logic [13:0] exp_seg;
    msg_len = 6'd2; div = 16'd0; scroll_en = 1'b0;
    do_reset();
    write_glyph(5'd0, 6'd13);
    write_glyph(5'd1, 6'd5);
    sync_frame();
    for (int k = 0; k < 12; k++) begin
      step();
      exp_seg = (k % 2 == 0) ? F_M : F_E;
      checks++;
      if (sel !== 12'(1 << k) || segm !== exp_seg) begin
        errors++;
        $display("FAIL static d=%0d: sel=%h segm=%b required sel=%h segm=%b", k, sel, segm, 12'(1 << k), exp_seg);
      end
    end
    checks++;
    if (frame_tick !== 1'b1) begin errors++; $display("FAIL static_frame_tick: got %b required 1", frame_tick); end
    step();
    checks++;
    if (sel !== 12'h001 || segm !== F_M || frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL static_wrap: sel=%h segm=%b ft=%b required sel=001 segm=%b ft=0", sel, segm, frame_tick, F_M);
    end
    $display("test_static done");
  endtask

  task automatic test_prescaler();
    int n;
    msg_len = 6'd2; div = 16'd3; scroll_en = 1'b0;
    do_reset();
    sync_frame();
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if (sel !== 12'h800 || frame_tick !== 1'b0) begin
        errors++;
        $display("FAIL presc_hold clk %0d: sel=%h ft=%b required sel=800 ft=0", i, sel, frame_tick);
      end
    end
    step();
    checks++;
    if (sel !== 12'h001) begin errors++; $display("FAIL presc_step: sel=%h required 001", sel); end
    n = 4;
    do begin
      step();
      n++;
    end while (!frame_tick && n < 200);
    checks++;
    if (n !== 48) begin errors++; $display("FAIL presc_frame_period: got %0d clks required 48", n); end
    $display("test_prescaler done");
  endtask

  task automatic test_scroll();
    logic [13:0] exp_seg [4];
    exp_seg[0] = F_A; exp_seg[1] = F_T; exp_seg[2] = F_E; exp_seg[3] = F_A;
    msg_len = 6'd3; div = 16'd0; scroll_en = 1'b0; scroll_div = 8'd0;
    do_reset();
    write_glyph(5'd0, 6'd1);
    write_glyph(5'd1, 6'd20);
    write_glyph(5'd2, 6'd5);
    sync_frame();
    scroll_en = 1'b1;
    for (int f = 0; f < 4; f++) begin
      step();
      checks++;
      if (sel !== 12'h001 || segm !== exp_seg[f]) begin
        errors++;
        $display("FAIL scroll frame %0d: sel=%h segm=%b required sel=001 segm=%b", f, sel, segm, exp_seg[f]);
      end
      repeat (11) step();
    end
    scroll_en = 1'b0;
    $display("test_scroll done");
  endtask

  task automatic test_shrink();
    msg_len = 6'd3; div = 16'd0; scroll_en = 1'b0; scroll_div = 8'd0;
    do_reset();
    write_glyph(5'd0, 6'd1);
    write_glyph(5'd1, 6'd20);
    write_glyph(5'd2, 6'd5);
    sync_frame();
    scroll_en = 1'b1;
    repeat (24) step();
    scroll_en = 1'b0;
    step();
    checks++;
    if (sel !== 12'h001 || segm !== F_E) begin
      errors++;
      $display("FAIL shrink_offset2: sel=%h segm=%b required sel=001 segm=%b", sel, segm, F_E);
    end
    repeat (5) step();
    msg_len = 6'd1;
    step();
    checks++;
    if (sel !== 12'h040 || segm !== F_A) begin
      errors++;
      $display("FAIL shrink_len1: sel=%h segm=%b required sel=040 segm=%b", sel, segm, F_A);
    end
    sync_frame();
    msg_len = 6'd3;
    step();
    checks++;
    if (sel !== 12'h001 || segm !== F_A) begin
      errors++;
      $display("FAIL shrink_offset_zeroed: sel=%h segm=%b required sel=001 segm=%b", sel, segm, F_A);
    end
    $display("test_shrink done");
  endtask

  task automatic test_empty_and_blank_code();
    msg_len = 6'd0; div = 16'd0; scroll_en = 1'b1; scroll_div = 8'd0;
    do_reset();
    write_glyph(5'd1, 6'd1);
    sync_frame();
    for (int k = 0; k < 12; k++) begin
      step();
      checks++;
      if (sel !== 12'(1 << k) || segm !== 14'h0) begin
        errors++;
        $display("FAIL empty d=%0d: sel=%h segm=%b required sel=%h segm=0", k, sel, segm, 12'(1 << k));
      end
    end
    scroll_en = 1'b0;
    write_glyph(5'd0, 6'd50);
    msg_len = 6'd2;
    sync_frame();
    step();
    checks++;
    if (sel !== 12'h001 || segm !== 14'h0) begin
      errors++;
      $display("FAIL glyph50: sel=%h segm=%b required sel=001 segm=0", sel, segm);
    end
    step();
    checks++;
    if (sel !== 12'h002 || segm !== F_A) begin
      errors++;
      $display("FAIL glyph50_neighbour: sel=%h segm=%b required sel=002 segm=%b", sel, segm, F_A);
    end
    $display("test_empty_and_blank_code done");
  endtask

  task automatic test_back_to_back_write();
    msg_len = 6'd2; div = 16'd0; scroll_en = 1'b0;
    do_reset();
    write_glyph(5'd0, 6'd13);
    write_glyph(5'd1, 6'd5);
    sync_frame();
    // Write lands on the same edge that reads address 0 for digit 0.
    write_glyph(5'd0, 6'd20);
    checks++;
    if (sel !== 12'h001 || segm !== F_M) begin
      errors++;
      $display("FAIL wr_collision_old: sel=%h segm=%b required sel=001 segm=%b", sel, segm, F_M);
    end
    step();
    checks++;
    if (sel !== 12'h002 || segm !== F_E) begin
      errors++;
      $display("FAIL wr_collision_d1: sel=%h segm=%b required sel=002 segm=%b", sel, segm, F_E);
    end
    step();
    checks++;
    if (sel !== 12'h004 || segm !== F_T) begin
      errors++;
      $display("FAIL wr_collision_new: sel=%h segm=%b required sel=004 segm=%b", sel, segm, F_T);
    end
    $display("test_back_to_back_write done");
  endtask

  task automatic test_mid_reset();
    msg_len = 6'd2; div = 16'd0; scroll_en = 1'b0;
    do_reset();
    write_glyph(5'd0, 6'd13);
    write_glyph(5'd1, 6'd5);
    sync_frame();
    repeat (6) step();
    checks++;
    if (sel !== 12'h020) begin errors++; $display("FAIL midrst_pre: sel=%h required 020", sel); end
    rst = 1'b1;
    step();
    checks++;
    if (sel !== 12'h000 || segm !== 14'h0 || frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL midrst_clear: sel=%h segm=%b ft=%b required 000/0/0", sel, segm, frame_tick);
    end
    rst = 1'b0;
    step();
    checks++;
    if (sel !== 12'h001 || segm !== 14'h0) begin
      errors++;
      $display("FAIL midrst_restart: sel=%h segm=%b required sel=001 segm=0", sel, segm);
    end
    step();
    checks++;
    if (sel !== 12'h002) begin errors++; $display("FAIL midrst_d1: sel=%h required 002", sel); end
    $display("test_mid_reset done");
  endtask

`ifdef SEG14_BLINK_EN
  task automatic test_blink();
    msg_len = 6'd1; div = 16'd0; scroll_en = 1'b0; blink = 1'b1;
    do_reset();
    write_glyph(5'd0, 6'd1);
    sync_frame();
    step();
    checks++;
    if (segm !== F_A) begin errors++; $display("FAIL blink_phase0: segm=%b required %b", segm, F_A); end
    repeat (31 * 12 - 1) step();
    step();
    checks++;
    if (sel !== 12'h001 || segm !== 14'h0) begin
      errors++;
      $display("FAIL blink_phase1: sel=%h segm=%b required sel=001 segm=0", sel, segm);
    end
    repeat (32 * 12) step();
    checks++;
    if (sel !== 12'h001 || segm !== F_A) begin
      errors++;
      $display("FAIL blink_phase0_again: sel=%h segm=%b required sel=001 segm=%b", sel, segm, F_A);
    end
    blink = 1'b0;
    $display("test_blink done");
  endtask
`endif

  initial begin
    rst = 1'b1; div = '0; wr_en = 1'b0; wr_addr = '0; wr_glyph = '0;
    msg_len = '0; scroll_en = 1'b0; scroll_div = '0; blink = 1'b0;
    test_reset();
    test_static();
    test_prescaler();
    test_scroll();
    test_shrink();
    test_empty_and_blank_code();
    test_back_to_back_write();
    test_mid_reset();
`ifdef SEG14_BLINK_EN
    test_blink();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
